// File: rtl/trap_sequencer.sv
// Supervisor trap/SRET sequencer: arbitrates events, flushes the pipeline, strobes the CSR
// trap write and issues one redirect. Define TRAP_VECTORED_EN for vectored interrupt targets.
module trap_sequencer #(
    parameter int XLEN          = 32,
    parameter int FLUSH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      cur_priv,
    input  logic [XLEN-1:0] cur_pc,
    input  logic            sstatus_sie,
    input  logic            sstatus_spp,
    input  logic [XLEN-1:0] csr_sie,
    input  logic [XLEN-1:0] csr_sip,
    input  logic [XLEN-1:0] csr_stvec,
    input  logic [XLEN-1:0] csr_sepc,
    input  logic [XLEN-1:0] time_value,
    input  logic [XLEN-1:0] stimecmp,
    input  logic            irq_ext,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            sret_req,
    output logic            evt_ready,
    output logic            flush_req,
    input  logic            flush_ack,
    output logic            trap_set,
    output logic            trap_is_irq,
    output logic [XLEN-1:0] trap_scause,
    output logic [XLEN-1:0] trap_sepc,
    output logic [XLEN-1:0] trap_stval,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      next_priv,
    input  logic            redirect_ready,
    output logic            do_sret,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_WRITE,
        S_REDIRECT
    } state_t;

    // Counter width caps usable FLUSH_TIMEOUT at 65535.
    localparam int              CW       = 16;
    localparam logic [XLEN-1:0] IRQ_MASK = XLEN'(32'h0000_0222);
    localparam logic [1:0]      PRIV_U   = 2'd0;
    localparam logic [1:0]      PRIV_S   = 2'd1;

    state_t          r_state;
    logic [CW-1:0]   r_flush_cnt;
    logic            r_evt_ready;
    logic            r_flush_req;
    logic            r_trap_set;
    logic            r_do_sret;
    logic            r_redirect_valid;
    logic            r_busy;
    logic            r_is_sret;
    logic            r_is_irq;
    logic [XLEN-1:0] r_scause;
    logic [XLEN-1:0] r_sepc;
    logic [XLEN-1:0] r_stval;
    logic [XLEN-1:0] r_target;
    logic [1:0]      r_next_priv;

    logic            w_stip;
    logic            w_gie;
    logic            w_irq;
    logic            w_timeout;
    logic [4:0]      w_code;
    logic [XLEN-1:0] w_pend;
    logic [XLEN-1:0] w_enabled;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_irq_target;

    assign w_stip    = (time_value >= stimecmp);
    assign w_pend    = csr_sip | (XLEN'(irq_ext) << 9) | (XLEN'(w_stip) << 5);
    assign w_enabled = w_pend & csr_sie & IRQ_MASK;
    assign w_gie     = (cur_priv == PRIV_U) || ((cur_priv == PRIV_S) && sstatus_sie);
    assign w_irq     = w_gie && (|w_enabled);
    assign w_base    = csr_stvec & ~XLEN'(3);
    assign w_timeout = (FLUSH_TIMEOUT != 0) && (r_flush_cnt >= CW'(FLUSH_TIMEOUT - 1));

    // SEI > SSI > STI; only meaningful when w_irq is set.
    always_comb begin
        w_code = 5'd5;
        if (w_enabled[9]) begin
            w_code = 5'd9;
        end else if (w_enabled[1]) begin
            w_code = 5'd1;
        end
    end

`ifdef TRAP_VECTORED_EN
    assign w_irq_target = (csr_stvec[1:0] == 2'b01) ? (w_base + (XLEN'(w_code) << 2)) : w_base;
`else
    assign w_irq_target = w_base;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_flush_cnt      <= '0;
            r_evt_ready      <= 1'b1;
            r_flush_req      <= 1'b0;
            r_trap_set       <= 1'b0;
            r_do_sret        <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
            r_is_sret        <= 1'b0;
            r_is_irq         <= 1'b0;
            r_scause         <= '0;
            r_sepc           <= '0;
            r_stval          <= '0;
            r_target         <= '0;
            r_next_priv      <= 2'd0;
        end else begin
            r_trap_set <= 1'b0;
            r_do_sret  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (exc_valid || sret_req || w_irq) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                        r_evt_ready <= 1'b0;
                        r_flush_req <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                    if (exc_valid) begin
                        r_is_sret   <= 1'b0;
                        r_is_irq    <= 1'b0;
                        r_scause    <= exc_cause;
                        r_sepc      <= exc_pc;
                        r_stval     <= exc_tval;
                        r_target    <= w_base;
                        r_next_priv <= PRIV_S;
                    end else if (sret_req) begin
                        // Trap CSR image is left untouched by SRET.
                        r_is_sret   <= 1'b1;
                        r_target    <= csr_sepc;
                        r_next_priv <= sstatus_spp ? PRIV_S : PRIV_U;
                    end else if (w_irq) begin
                        r_is_sret   <= 1'b0;
                        r_is_irq    <= 1'b1;
                        r_scause    <= {1'b1, {(XLEN-6){1'b0}}, w_code};
                        r_sepc      <= cur_pc;
                        r_stval     <= '0;
                        r_target    <= w_irq_target;
                        r_next_priv <= PRIV_S;
                    end
                end
                S_FLUSH: begin
                    if (flush_ack || w_timeout) begin
                        r_state     <= S_WRITE;
                        r_flush_req <= 1'b0;
                        r_trap_set  <= !r_is_sret;
                        r_do_sret   <= r_is_sret;
                    end else if (r_flush_cnt != {CW{1'b1}}) begin
                        r_flush_cnt <= r_flush_cnt + CW'(1);
                    end
                end
                S_WRITE: begin
                    r_state          <= S_REDIRECT;
                    r_redirect_valid <= 1'b1;
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state          <= S_IDLE;
                        r_redirect_valid <= 1'b0;
                        r_busy           <= 1'b0;
                        r_evt_ready      <= 1'b1;
                    end
                end
                default: begin
                    r_state          <= S_IDLE;
                    r_flush_req      <= 1'b0;
                    r_redirect_valid <= 1'b0;
                    r_busy           <= 1'b0;
                    r_evt_ready      <= 1'b1;
                end
            endcase
        end
    end

    assign evt_ready      = r_evt_ready;
    assign flush_req      = r_flush_req;
    assign trap_set       = r_trap_set;
    assign do_sret        = r_do_sret;
    assign redirect_valid = r_redirect_valid;
    assign busy           = r_busy;
    assign trap_is_irq    = r_is_irq;
    assign trap_scause    = r_scause;
    assign trap_sepc      = r_sepc;
    assign trap_stval     = r_stval;
    assign redirect_pc    = r_target;
    assign next_priv      = r_next_priv;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios with literal expectations, then random
// stimulus checked every cycle against an event-level reference model.
module tb_trap_sequencer;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cur_priv;
    logic [31:0] cur_pc;
    logic        sstatus_sie;
    logic        sstatus_spp;
    logic [31:0] csr_sie;
    logic [31:0] csr_sip;
    logic [31:0] csr_stvec;
    logic [31:0] csr_sepc;
    logic [31:0] time_value;
    logic [31:0] stimecmp;
    logic        irq_ext;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] exc_pc;
    logic        sret_req;
    logic        evt_ready;
    logic        flush_req;
    logic        flush_ack;
    logic        trap_set;
    logic        trap_is_irq;
    logic [31:0] trap_scause;
    logic [31:0] trap_sepc;
    logic [31:0] trap_stval;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  next_priv;
    logic        redirect_ready;
    logic        do_sret;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    trap_sequencer #(.XLEN(32), .FLUSH_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .cur_priv(cur_priv), .cur_pc(cur_pc),
        .sstatus_sie(sstatus_sie), .sstatus_spp(sstatus_spp),
        .csr_sie(csr_sie), .csr_sip(csr_sip), .csr_stvec(csr_stvec), .csr_sepc(csr_sepc),
        .time_value(time_value), .stimecmp(stimecmp), .irq_ext(irq_ext),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
        .sret_req(sret_req), .evt_ready(evt_ready), .flush_req(flush_req), .flush_ack(flush_ack),
        .trap_set(trap_set), .trap_is_irq(trap_is_irq), .trap_scause(trap_scause),
        .trap_sepc(trap_sepc), .trap_stval(trap_stval), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .next_priv(next_priv), .redirect_ready(redirect_ready),
        .do_sret(do_sret), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_redirect();
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
    endtask

    // Reference model: phase 0 idle, 1 flushing, 2 CSR write slot, 3 redirect pending.
    int          m_phase = 0;
    bit          m_sync  = 1'b0;
    bit          m_sret;
    bit          m_irq;
    int          m_fcnt;
    int          m_txn   = 0;
    logic [31:0] m_scause, m_sepc, m_stval, m_target;
    logic [1:0]  m_priv;

    always @(negedge clk) begin
        logic [31:0] pend, en;
        logic        stip, gie;
        int          prio[3];
        int          code;
        if (m_sync) begin
            check("evt_ready", 64'(evt_ready), 64'(m_phase == 0));
            check("busy", 64'(busy), 64'(m_phase != 0));
            check("flush_req", 64'(flush_req), 64'(m_phase == 1));
            check("trap_set", 64'(trap_set), 64'(m_phase == 2 && !m_sret));
            check("do_sret", 64'(do_sret), 64'(m_phase == 2 && m_sret));
            check("redirect_valid", 64'(redirect_valid), 64'(m_phase == 3));
            if (m_phase == 2 && !m_sret) begin
                check("trap_scause", 64'(trap_scause), 64'(m_scause));
                check("trap_sepc", 64'(trap_sepc), 64'(m_sepc));
                check("trap_stval", 64'(trap_stval), 64'(m_stval));
                check("trap_is_irq", 64'(trap_is_irq), 64'(m_irq));
            end
            if (m_phase == 3) begin
                check("redirect_pc", 64'(redirect_pc), 64'(m_target));
                check("next_priv", 64'(next_priv), 64'(m_priv));
            end
        end
        if (rst) begin
            m_phase = 0;
            m_sync  = 1'b1;
        end else begin
            case (m_phase)
                0: begin
                    stip = (time_value >= stimecmp);
                    pend = csr_sip | (32'(irq_ext) << 9) | (32'(stip) << 5);
                    en   = pend & csr_sie & 32'h222;
                    gie  = (cur_priv == 2'd0) || (cur_priv == 2'd1 && sstatus_sie);
                    if (exc_valid) begin
                        m_sret = 1'b0; m_irq = 1'b0;
                        m_scause = exc_cause; m_sepc = exc_pc; m_stval = exc_tval;
                        m_target = csr_stvec & ~32'h3; m_priv = 2'd1;
                        m_phase = 1; m_fcnt = 0;
                    end else if (sret_req) begin
                        m_sret = 1'b1;
                        m_target = csr_sepc; m_priv = sstatus_spp ? 2'd1 : 2'd0;
                        m_phase = 1; m_fcnt = 0;
                    end else if (gie && en != 0) begin
                        prio = '{9, 1, 5};
                        code = 5;
                        for (int i = 2; i >= 0; i--) if (en[prio[i]]) code = prio[i];
                        m_sret = 1'b0; m_irq = 1'b1;
                        m_scause = 32'h8000_0000 + 32'(code); m_sepc = cur_pc; m_stval = 0;
                        m_target = csr_stvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
                        if (csr_stvec[1:0] == 2'b01) m_target = m_target + 32'(4 * code);
`endif
                        m_priv = 2'd1;
                        m_phase = 1; m_fcnt = 0;
                    end
                end
                1: begin
                    m_fcnt++;
                    if (flush_ack || (TO != 0 && m_fcnt >= TO)) m_phase = 2;
                end
                2: m_phase = 3;
                default: begin
                    if (redirect_ready) begin
                        m_txn++;
                        $display("[TB] txn %0d %s cause=0x%08h target=0x%08h priv=%0d",
                                 m_txn, m_sret ? "sret" : (m_irq ? "irq " : "exc "),
                                 m_scause, m_target, m_priv);
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    initial begin
        int k;
        rst = 1'b1; cur_priv = 2'd1; cur_pc = 0; sstatus_sie = 0; sstatus_spp = 0;
        csr_sie = 0; csr_sip = 0; csr_stvec = 32'h8000; csr_sepc = 0;
        time_value = 0; stimecmp = 32'hFFFF_FFFF; irq_ext = 0;
        exc_valid = 0; exc_cause = 0; exc_tval = 0; exc_pc = 0; sret_req = 0;
        flush_ack = 1; redirect_ready = 0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset evt_ready", 64'(evt_ready), 64'd1);
        check("reset busy", 64'(busy), 64'd0);
        check("reset redirect_pc", 64'(redirect_pc), 64'd0);
        check("reset trap_scause", 64'(trap_scause), 64'd0);
        check("reset next_priv", 64'(next_priv), 64'd0);

        // Exception, ack on first flush cycle, 3-cycle accept-to-redirect.
        exc_valid = 1; exc_cause = 2; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        tick();
        exc_valid = 0;
        check("t1 flush_req", 64'(flush_req), 64'd1);
        tick();
        check("t1 trap_set", 64'(trap_set), 64'd1);
        check("t1 scause", 64'(trap_scause), 64'd2);
        check("t1 sepc", 64'(trap_sepc), 64'h100);
        check("t1 stval", 64'(trap_stval), 64'hDEAD);
        check("t1 is_irq", 64'(trap_is_irq), 64'd0);
        tick();
        check("t1 redirect_valid", 64'(redirect_valid), 64'd1);
        check("t1 redirect_pc", 64'(redirect_pc), 64'h8000);
        check("t1 next_priv", 64'(next_priv), 64'd1);
        finish_redirect();
        check("t1 back idle", 64'(evt_ready), 64'd1);

        // SEI beats SSI.
        sstatus_sie = 1; csr_sie = 32'h222; irq_ext = 1; csr_sip = 32'h2; cur_pc = 32'h200;
        tick();
        irq_ext = 0; csr_sip = 0;
        tick();
        check("t2 scause", 64'(trap_scause), 64'h8000_0009);
        check("t2 sepc", 64'(trap_sepc), 64'h200);
        check("t2 stval", 64'(trap_stval), 64'd0);
        check("t2 is_irq", 64'(trap_is_irq), 64'd1);
        tick();
        check("t2 redirect_pc", 64'(redirect_pc), 64'h8000);
        finish_redirect();

        // Timer equality in U-mode, then off-by-one and M-mode masking.
        cur_priv = 2'd0; sstatus_sie = 0; csr_sie = 32'h20; time_value = 32'h50; stimecmp = 32'h50;
        tick();
        stimecmp = 32'hFFFF_FFFF;
        tick();
        check("t3 scause", 64'(trap_scause), 64'h8000_0005);
        tick();
        finish_redirect();
        stimecmp = 32'h51;
        repeat (3) tick();
        check("t3 no trap cmp+1", 64'(busy), 64'd0);
        cur_priv = 2'd3; stimecmp = 32'h50;
        repeat (3) tick();
        check("t3 no trap in M", 64'(busy), 64'd0);
        stimecmp = 32'hFFFF_FFFF; cur_priv = 2'd1;

        // Exception beats SRET; SRET retried afterwards.
        exc_valid = 1; exc_cause = 8; exc_pc = 32'h400; exc_tval = 0; sret_req = 1;
        csr_sepc = 32'h300; sstatus_spp = 0;
        tick();
        exc_valid = 0;
        tick();
        check("t4 exc trap_set", 64'(trap_set), 64'd1);
        check("t4 exc do_sret", 64'(do_sret), 64'd0);
        check("t4 exc scause", 64'(trap_scause), 64'd8);
        tick();
        finish_redirect();
        tick();
        sret_req = 0;
        tick();
        check("t4 do_sret", 64'(do_sret), 64'd1);
        check("t4 sret trap_set", 64'(trap_set), 64'd0);
        tick();
        check("t4 sret redirect_pc", 64'(redirect_pc), 64'h300);
        check("t4 sret next_priv", 64'(next_priv), 64'd0);
        finish_redirect();

        // Flush timeout, then reset in REDIRECT.
        flush_ack = 0; exc_valid = 1; exc_cause = 4; exc_pc = 32'h500;
        tick();
        exc_valid = 0;
        k = 0;
        while (!trap_set && k < 40) begin
            tick();
            k++;
        end
        check("t5 timeout cycles", 64'(k), 64'd15);
        tick();
        check("t5 in redirect", 64'(redirect_valid), 64'd1);
        rst = 1;
        tick();
        rst = 0;
        check("t5 rst redirect_valid", 64'(redirect_valid), 64'd0);
        check("t5 rst busy", 64'(busy), 64'd0);
        check("t5 rst evt_ready", 64'(evt_ready), 64'd1);
        flush_ack = 1;

`ifdef TRAP_VECTORED_EN
        csr_stvec = 32'h8001; cur_priv = 2'd0; csr_sie = 32'h20; time_value = 32'h50; stimecmp = 32'h50;
        tick();
        stimecmp = 32'hFFFF_FFFF;
        tick(); tick();
        check("t6 vectored sti", 64'(redirect_pc), 64'h8014);
        finish_redirect();
        exc_valid = 1; exc_cause = 2;
        tick();
        exc_valid = 0;
        tick(); tick();
        check("t6 vectored exc", 64'(redirect_pc), 64'h8000);
        finish_redirect();
        csr_stvec = 32'h8000;
`endif

        // Random phase: model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            case ($urandom_range(0, 2))
                0: cur_priv = 2'd0;
                1: cur_priv = 2'd1;
                default: cur_priv = 2'd3;
            endcase
            sstatus_sie = 1'($urandom);
            sstatus_spp = 1'($urandom);
            csr_sie     = $urandom_range(0, 1) ? 32'h222 : $urandom;
            csr_sip     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            irq_ext     = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) begin
                time_value = $urandom_range(0, 7);
                stimecmp   = $urandom_range(0, 7);
            end else begin
                time_value = $urandom;
                stimecmp   = $urandom;
            end
            csr_stvec      = $urandom;
            csr_sepc       = $urandom;
            cur_pc         = $urandom;
            exc_valid      = ($urandom_range(0, 5) == 0);
            exc_cause      = $urandom & 32'h7FFF_FFFF;
            exc_tval       = $urandom;
            exc_pc         = $urandom;
            sret_req       = ($urandom_range(0, 5) == 0);
            flush_ack      = ($urandom_range(0, 2) != 0);
            redirect_ready = 1'($urandom);
            tick();
        end
        rst = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
